// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multicycle RV32I control FSM driving a Wishbone classic master.
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK/BRANCH and halts in a sticky TRAP.
// Optional bus watchdog: define MC_CTRL_TIMEOUT_EN to enable it.
module mc_ctrl_fsm #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_lt,
    input  logic              alu_ltu,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic              pc_write,
    output logic              ir_write,
    output logic              pc_src,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic              reg_write,
    output logic [1:0]        wb_src,
    output logic [ADDR_W-1:0] alu_out_reg,
    output logic              trap_o,
    output logic [1:0]        trap_cause,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_BRANCH    = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b00;
    localparam logic [1:0] CAUSE_BUS      = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // Reject parameter values the address/sel logic and watchdog cannot handle.
    if (ADDR_W < 3 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("mc_ctrl_fsm: ADDR_W must be >= 3 and TIMEOUT_CYCLES >= 2");
    end

    state_t            state_q;
    logic [ADDR_W-1:0] alu_out_q;
    logic [1:0]        trap_cause_q;

    // Instruction class decode (IR is stable from DECODE onwards).
    logic is_load, is_store, is_branch, is_jal, is_jalr, is_known;
    logic misaligned, ls_f3_ok, br_f3_ok, br_taken;
    logic bus_wait, wd_expired;

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_known  = is_load || is_store || is_branch || is_jal || is_jalr ||
                       (opcode == OP_R) || (opcode == OP_IMM) ||
                       (opcode == OP_LUI) || (opcode == OP_AUIPC);

    // funct3[1:0] encodes access size for both loads and stores.
    assign misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                        ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
    assign ls_f3_ok   = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                : (funct3 inside {3'b000, 3'b001, 3'b010});
    assign br_f3_ok   = (funct3[2:1] != 2'b01);

    // Branch condition: funct3[2:1] picks the flag, funct3[0] inverts it.
    always_comb begin
        case (funct3[2:1])
            2'b00:   br_taken = alu_zero ^ funct3[0];
            2'b10:   br_taken = alu_lt   ^ funct3[0];
            2'b11:   br_taken = alu_ltu  ^ funct3[0];
            default: br_taken = 1'b0;
        endcase
    end

    assign bus_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !wb_ack_i && !wb_err_i;

`ifdef MC_CTRL_TIMEOUT_EN
    localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt_q;

    assign wd_expired = bus_wait && (wd_cnt_q == WD_LAST);

    // Watchdog counts consecutive bus-wait cycles; cleared whenever no wait is pending.
    always_ff @(posedge wb_clk) begin
        if (wb_rst || !bus_wait) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    // State sequencing, ALU result capture and sticky trap cause.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q      <= S_FETCH;
            alu_out_q    <= '0;
            trap_cause_q <= CAUSE_ILLEGAL;
        end else begin
            case (state_q)
                S_FETCH, S_MEM: begin
                    if (wb_err_i) begin
                        state_q      <= S_TRAP;
                        trap_cause_q <= CAUSE_BUS;
                    end else if (wb_ack_i) begin
                        if (state_q == S_FETCH) state_q <= S_DECODE;
                        else if (is_load)       state_q <= S_WRITEBACK;
                        else                    state_q <= S_FETCH;
                    end else if (wd_expired) begin
                        state_q      <= S_TRAP;
                        trap_cause_q <= CAUSE_TIMEOUT;
                    end
                end
                S_DECODE: state_q <= S_EXECUTE;
                S_EXECUTE: begin
                    alu_out_q <= alu_result;
                    if (!is_known) begin
                        state_q      <= S_TRAP;
                        trap_cause_q <= CAUSE_ILLEGAL;
                    end else if (is_load || is_store) begin
                        if (misaligned) begin
                            state_q      <= S_TRAP;
                            trap_cause_q <= CAUSE_MISALIGN;
                        end else if (!ls_f3_ok) begin
                            state_q      <= S_TRAP;
                            trap_cause_q <= CAUSE_ILLEGAL;
                        end else begin
                            state_q <= S_MEM;
                        end
                    end else if (is_branch) begin
                        if (!br_f3_ok) begin
                            state_q      <= S_TRAP;
                            trap_cause_q <= CAUSE_ILLEGAL;
                        end else begin
                            state_q <= br_taken ? S_BRANCH : S_FETCH;
                        end
                    end else begin
                        state_q <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK, S_BRANCH: state_q <= S_FETCH;
                default: state_q <= S_TRAP;
            endcase
        end
    end

    // Bus and datapath controls: decoded from state plus ack/err, all forced low in reset.
    always_comb begin
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_adr_o  = '0;
        wb_sel_o  = 4'b0000;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        pc_src    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        reg_write = 1'b0;
        wb_src    = 2'b00;
        trap_o    = 1'b0;
        if (!wb_rst) begin
            case (state_q)
                S_FETCH: begin
                    wb_cyc_o  = 1'b1;
                    wb_stb_o  = 1'b1;
                    wb_sel_o  = 4'b1111;
                    wb_adr_o  = pc_i;
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ir_write  = wb_ack_i && !wb_err_i;
                    pc_write  = wb_ack_i && !wb_err_i;
                end
                S_EXECUTE: begin
                    case (opcode)
                        OP_R:      alu_op = 2'b10;
                        OP_IMM:    begin alu_src_b = 2'b01; alu_op = 2'b10; end
                        OP_LOAD, OP_STORE, OP_JALR: alu_src_b = 2'b01;
                        OP_BRANCH: alu_op = 2'b01;
                        OP_JAL, OP_AUIPC: begin alu_src_a = 1'b1; alu_src_b = 2'b01; end
                        OP_LUI:    begin alu_src_b = 2'b01; alu_op = 2'b11; end
                        default:   ;
                    endcase
                end
                S_MEM: begin
                    wb_cyc_o = 1'b1;
                    wb_stb_o = 1'b1;
                    wb_we_o  = is_store;
                    wb_adr_o = {alu_out_q[ADDR_W-1:2], 2'b00};
                    case (funct3[1:0])
                        2'b00:   wb_sel_o = 4'b0001 << alu_out_q[1:0];
                        2'b01:   wb_sel_o = alu_out_q[1] ? 4'b1100 : 4'b0011;
                        default: wb_sel_o = 4'b1111;
                    endcase
                end
                S_WRITEBACK: begin
                    reg_write = 1'b1;
                    if (is_load) begin
                        wb_src = 2'b01;
                    end else if (is_jal || is_jalr) begin
                        wb_src   = 2'b10;
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = 1'b1;
                end
                S_TRAP:  trap_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign alu_out_reg = wb_rst ? '0 : alu_out_q;
    assign trap_cause  = wb_rst ? 2'b00 : trap_cause_q;
    assign fsm_state   = wb_rst ? 3'd0 : state_q;

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multicycle control FSM for the RV32I core, successor to the fixed-width control unit. It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK/BRANCH and drives a Wishbone classic master port. It adds:
- full conditional-branch decode;
- byte/halfword select generation;
- registered bus address and a real fetch address;
- a sticky TRAP state for illegal opcodes, bus errors, misalignment and an optional bus watchdog.

## Interface
Parameters:
- ADDR_W, 32, address/ALU width (≥ 3).
- TIMEOUT_CYCLES, 16, bus watchdog limit in cycles (≥ 2; used only with MC_CTRL_TIMEOUT_EN).

Ports:
- wb_clk  in  1  clock; all state changes on rising edge.
- wb_rst  in  1  reset; one clock, synchronous, active-high.
- opcode  in  7  instruction[6:0] from IR.
- funct3  in  3  instruction[14:12] from IR.
- pc_i  in  ADDR_W  current PC, used as fetch address.
- alu_result  in  ADDR_W  combinational ALU output.
- alu_zero / alu_lt / alu_ltu  in  1 each  ALU compare flags: equal, signed less-than, unsigned less-than.
- wb_ack_i / wb_err_i  in  1 each  Wishbone acknowledge / error.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone controls.
- wb_adr_o  out  ADDR_W  word-aligned bus address.
- wb_sel_o  out  4  byte lanes.
- pc_write, ir_write  out  1  PC / IR load enables.
- pc_src  out  1  0 = alu_result (PC+4), 1 = alu_out_reg (jump/branch target).
- alu_src_a  out  1  0 = rs1, 1 = PC of current instruction.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4.
- alu_op  out  2  00 add, 01 sub/compare, 10 funct decode, 11 pass B.
- reg_write  out  1  register-file write enable.
- wb_src  out  2  rd source: 00 alu_out_reg, 01 load data, 10 PC+4.
- alu_out_reg  out  ADDR_W  registered ALU result.
- trap_o  out  1  core halted.
- trap_cause  out  2  00 illegal, 01 bus err, 10 misaligned, 11 timeout.
- fsm_state  out  3  FETCH 0, DECODE 1, EXECUTE 2, MEM 3, WRITEBACK 4, BRANCH 5, TRAP 6.

## Operation
- FETCH: cyc=stb=1, we=0, sel=1111, adr=pc_i; alu_src_a=1, alu_src_b=10, alu_op=00.
  - On ack: ir_write=pc_write=1, pc_src=0, go to DECODE.
  - On err: go to TRAP, cause 01.
- DECODE: no outputs asserted; go to EXECUTE.
- EXECUTE: operand selects per opcode (R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC). alu_out_reg captures alu_result on this edge only. Next state:
  - Unknown opcode → TRAP, cause 00.
  - LOAD/STORE:
    - Misaligned → TRAP, cause 10. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
    - Illegal funct3 → TRAP, cause 00. Legal: LB/LH/LW/LBU/LHU, SB/SH/SW.
    - Otherwise → MEM.
  - BRANCH: taken per funct3 (BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu) → BRANCH. Not taken → FETCH. funct3 010/011 → TRAP, cause 00.
  - All others → WRITEBACK.
- MEM: cyc=stb=1, we=STORE, adr={alu_out_reg[ADDR_W-1:2],2'b00}.
  - sel: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
  - ack → WRITEBACK (load) or FETCH (store). err → TRAP, cause 01.
- WRITEBACK: reg_write=1.
  - wb_src = 01 for load, 10 for JAL/JALR, else 00.
  - JAL/JALR also assert pc_write=1, pc_src=1. JALR target bit0 is cleared by the datapath.
  - Next state: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=01, alu_op=00; pc_write=1, pc_src=0; next state FETCH.
- TRAP: trap_o=1, trap_cause held; all bus and write enables 0; remains until wb_rst.

## Timing
- Bus and enable outputs are combinational from state plus ack/err. The bus address is registered, so it is stable for the whole MEM cycle.
- cyc/stb stay high until the ack/err cycle and drop the following cycle. Minimum bus latency is one cycle; there is no cap without the watchdog.
- ack and err in the same cycle: err wins.
- Reset:
  - While wb_rst=1: state=FETCH, alu_out_reg=0, trap_cause=00, watchdog=0.
  - All outputs are forced 0 (including cyc/stb) while wb_rst=1.
  - FETCH bus request starts the first cycle after release.
  - Reset mid-transaction aborts it; cyc drops in the reset cycle.
- Instruction cycle counts with 1-cycle ack: ALU 4, load 5, store 4, branch taken 4 / not taken 3, JAL 4.

## Configuration
- MC_CTRL_TIMEOUT_EN defined:
  - Counter clears on entry to FETCH/MEM and increments each bus-wait cycle without ack/err.
  - On the TIMEOUT_CYCLES-th wait cycle with no ack/err, go to TRAP with cause 11 and drop cyc.
  - ack arriving on that cycle wins.
- Undefined: no counter logic; the FSM waits indefinitely; cause 11 is never produced.

## Test plan
- ADDI x1,x0,5, ack in 1 cycle → fsm_state 0,1,2,4,0; reg_write=1 only in state 4; pc_write with ir_write in FETCH.
- SB at alu_result 0x1003, ack after 3 wait cycles → wb_sel_o=1000, wb_adr_o=0x1000, wb_we_o=1 for 4 cycles, then FETCH.
- BLT with alu_lt=1 → BRANCH with pc_write=1, pc_src=0; BGE with alu_lt=1 → FETCH directly; funct3=010 → trap_cause=00.
- LW at 0x1002 → TRAP, trap_cause=10, no MEM bus cycle issued; wb_rst clears it and the next FETCH uses adr=pc_i.
- FETCH with wb_err_i=1 and wb_ack_i=1 together → TRAP, cause 01, ir_write=0.
- With MC_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → TRAP cause 11 after 4 wait cycles; ack on the 4th cycle → DECODE.
